serial_negate_unit: RTL and testbench

- Downstream of the 4-bit inverter in the ALU datapath.
- Consumes the one's-complement word (~x) and adds 1 bit-serially, producing the two's-complement negation (-x) for the ALU SUB/NEG path.
- Uses a start/busy/done handshake: one bit per clock, LSB first, with result, carry-out and overflow flags.

---
 rtl/alu_pkg.sv | 12 +
 rtl/serial_half_adder_bit.sv | 12 +
 rtl/serial_negate_unit.sv | 127 ++++++++++++
 tb/tb_serial_negate_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and default datapath width.
package alu_pkg;

    localparam int unsigned ALU_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_half_adder_bit.sv
// One-bit half adder used to ripple the +1 through the operand serially.
module serial_half_adder_bit (
    input  logic a,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ cin;
    assign cout = a & cin;

endmodule

// File: rtl/serial_negate_unit.sv
// Bit-serial +1 on a one's-complement word, producing the two's-complement negation.
// Optional macro SERIAL_NEGATE_EARLY_TERM_EN: finish as soon as the carry dies out.
module serial_negate_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] op,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_src;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_op;
    logic               r_cout;
    logic               r_ovf;

    logic               w_ha_s;
    logic               w_ha_cout;
    logic               w_last;
    logic               w_accept;
    logic               w_finish;
    logic [WIDTH-1:0]   w_res_nxt;

    serial_half_adder_bit u_ha (
        .a    (r_src[r_cnt]),
        .cin  (r_carry),
        .s    (w_ha_s),
        .cout (w_ha_cout)
    );

    // Final SHIFT step: last bit reached, or (early-term build) carry no longer propagates.
`ifdef SERIAL_NEGATE_EARLY_TERM_EN
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || !w_ha_cout;
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_finish  = (r_state == ST_SHIFT) && w_last;
        w_res_nxt = r_res;
        if (r_state == ST_SHIFT) begin
            w_res_nxt[r_cnt] = w_ha_s;
`ifdef SERIAL_NEGATE_EARLY_TERM_EN
            // With the carry gone, the remaining upper bits pass through unchanged.
            if (!w_ha_cout) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (CNT_W'(i) > r_cnt) w_res_nxt[i] = r_src[i];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_SHIFT);
            r_done <= w_finish;
            if (w_accept) begin
                r_src   <= inp;
                r_carry <= 1'b1;
                r_cnt   <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_res   <= w_res_nxt;
                r_carry <= w_ha_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            // Flags are captured together with the result on DONE entry.
            if (w_finish) begin
                r_op   <= w_res_nxt;
                r_cout <= w_ha_cout;
                r_ovf  <= ~r_src[WIDTH-1] & w_res_nxt[WIDTH-1];
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign op   = r_op;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_negate_unit.sv
// Directed bench for serial_negate_unit (WIDTH=4), both latency variants.
module tb_serial_negate_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] inp;
    logic       busy;
    logic       done;
    logic [3:0] op;
    logic       cout;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SERIAL_NEGATE_EARLY_TERM_EN
    localparam int S1100 = 1;
    localparam int S1110 = 1;
    localparam int S0001 = 2;
`else
    localparam int S1100 = 4;
    localparam int S1110 = 4;
    localparam int S0001 = 4;
`endif
    localparam int S1111 = 4;
    localparam int S0111 = 4;

    serial_negate_unit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .inp   (inp),
        .busy  (busy),
        .done  (done),
        .op    (op),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge; returns #1 into cycle 1 of the conversion.
    task automatic apply_start(input logic [3:0] v);
        @(negedge clk);
        start = 1'b1;
        inp   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Step until done (bounded); cyc is the done cycle (0 on timeout).
    task automatic wait_done(output int cyc, output int nbusy, output bit both);
        cyc   = 1;
        nbusy = 0;
        both  = 1'b0;
        while (done !== 1'b1 && cyc <= 20) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (done !== 1'b1) cyc = 0;
        else both = (busy === 1'b1);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        inp   = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({busy, done, op, cout, ovf} !== 8'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got busy=%b done=%b op=%b cout=%b ovf=%b, want all 0",
                         k, busy, done, op, cout, ovf);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_basic();
        int cyc; int nb; bit both;
        apply_start(4'b1100);
        wait_done(cyc, nb, both);
        n_checks++;
        if (cyc != S1100 + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", cyc, S1100 + 1); end
        n_checks++;
        if (nb != S1100) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", nb, S1100); end
        n_checks++;
        if (both !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done_overlap: got %b want 0", both); end
        n_checks++;
        if ({op, cout, ovf} !== {4'b1101, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got op=%b cout=%b ovf=%b want 1101/0/0", op, cout, ovf);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || op !== 4'b1101) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: got done=%b op=%b want 0/1101", done, op);
        end
    endtask

    task automatic test_wrap();
        int cyc; int nb; bit both;
        apply_start(4'b1111);
        wait_done(cyc, nb, both);
        n_checks++;
        if (cyc != S1111 + 1) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", cyc, S1111 + 1); end
        n_checks++;
        if ({op, cout, ovf} !== {4'b0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_result: got op=%b cout=%b ovf=%b want 0000/1/0", op, cout, ovf);
        end
    endtask

    task automatic test_overflow();
        int cyc; int nb; bit both;
        apply_start(4'b0111);
        wait_done(cyc, nb, both);
        n_checks++;
        if (cyc != S0111 + 1) begin n_fail++; $display("FAIL ovf_latency: got %0d want %0d", cyc, S0111 + 1); end
        n_checks++;
        if ({op, cout, ovf} !== {4'b1000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_result: got op=%b cout=%b ovf=%b want 1000/0/1", op, cout, ovf);
        end
    endtask

    task automatic test_back_to_back();
        int cyc1; int cyc2; int nb; bit both;
        apply_start(4'b1110);
        // Start held high from here on: ignored while busy, accepted in DONE.
        start = 1'b1;
        inp   = 4'b0001;
        wait_done(cyc1, nb, both);
        n_checks++;
        if (cyc1 != S1110 + 1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc1, S1110 + 1); end
        n_checks++;
        if ({op, cout, ovf} !== {4'b1111, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first_result: got op=%b cout=%b ovf=%b want 1111/0/0", op, cout, ovf);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || op !== 4'b1111) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b done=%b op=%b want 1/0/1111", busy, done, op);
        end
        wait_done(cyc2, nb, both);
        n_checks++;
        if (cyc2 != S0001 + 1) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d want %0d", cyc2, S0001 + 1); end
        n_checks++;
        if ({op, cout, ovf} !== {4'b0010, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second_result: got op=%b cout=%b ovf=%b want 0010/0/0", op, cout, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        int cyc; int nb; bit both;
        int seen_done;
        apply_start(4'b1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, done, op, cout, ovf} !== 8'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got busy=%b done=%b op=%b cout=%b ovf=%b want all 0",
                     busy, done, op, cout, ovf);
        end
        seen_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen_done); end
        apply_start(4'b1100);
        wait_done(cyc, nb, both);
        n_checks++;
        if (cyc != S1100 + 1 || op !== 4'b1101) begin
            n_fail++;
            $display("FAIL midrst_rerun: got cyc=%0d op=%b want %0d/1101", cyc, op, S1100 + 1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        inp   = 4'b0000;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
